// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus slave port between NREQ masters.
// Optional watchdog abort of unacknowledged transactions: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    m_req,
  input  logic [NREQ-1:0]    m_we,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*DW-1:0] m_wdata,
  output logic [NREQ-1:0]    m_ack,
  output logic [NREQ-1:0]    m_err,
  output logic [DW-1:0]      m_rdata,
  output logic               s_req,
  output logic               s_we,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic               s_ack,
  input  logic [DW-1:0]      s_rdata,
  output logic               busy,
  output logic [2:0]         gnt_idx
);

  // state | meaning
  // IDLE  | no transaction; arbitrate m_req starting at ptr
  // BUSY  | granted master routed to slave; wait for s_ack (or watchdog)
  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      ptr_nxt;
  logic            found;
  logic [2:0]      win;
  logic [3:0]      cand;
  logic [NREQ-1:0] gnt_oh;
  logic            tmo;

  // Rotating priority search: first requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && cand[2:0] == 3'(j) && m_req[j]) begin
          found = 1'b1;
          win   = 3'(j);
        end
      end
    end
  end

  assign ptr_nxt = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) gnt_oh[i] = (gnt_idx == 3'(i));
  end

  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_idx == 3'(i)) begin
          s_we    = m_we[i];
          s_addr  = m_addr[i*AW +: AW];
          s_wdata = m_wdata[i*DW +: DW];
        end
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  // s_ack in the final watchdog cycle wins over the abort.
  assign tmo = (state == BUSY) && !s_ack && (cnt == 16'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  assign busy    = (state == BUSY);
  assign s_req   = busy;
  assign m_rdata = s_rdata;
  assign m_ack   = (busy && s_ack) ? gnt_oh : '0;
  assign m_err   = tmo ? gnt_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_idx <= 3'd0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt     <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx <= win;
            state   <= BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt     <= 16'd0;
`endif
          end
        end
        BUSY: begin
          if (s_ack || tmo) begin
            state <= IDLE;
            ptr   <= ptr_nxt;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus randomized traffic scored against a transaction-level model.
module tb_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_ack, m_err;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;
  logic            busy;
  logic [2:0]      gnt_idx;

  bus_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t q[$];
  bit   mon_en   = 1'b0;
  bit   exp_busy = 1'b0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    m_req[i]           = req;
    m_we[i]            = we;
    m_addr[i*AW +: AW] = addr;
    m_wdata[i*DW +: DW] = wdata;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    cyc();
    rst = 1'b1;
  endtask

  // Scoreboard monitor: checks every cycle, pops an expected transaction on each slave ack.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rnd_busy", busy, exp_busy);
      chk("rnd_err_quiet", m_err, 0);
      if (s_req && s_ack) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_ack", 1, 0);
        end else begin
          txn_t e;
          e = q.pop_front();
          chk("rnd_gnt", gnt_idx, e.idx);
          chk("rnd_addr", s_addr, e.addr);
          chk("rnd_we", s_we, e.we);
          chk("rnd_wdata", s_wdata, e.wdata);
          chk("rnd_ack", m_ack, 64'(1) << e.idx);
          chk("rnd_rdata", m_rdata, s_rdata);
          done_cnt++;
        end
      end else begin
        chk("rnd_ack_quiet", m_ack, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mbusy;
    int mgnt, mptr, mcnt;

    // Reset values
    rst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_swdata", s_wdata, 0);
    chk("rst_swe", s_we, 0);
    chk("rst_gnt", gnt_idx, 0);
    cyc();
    rst = 1'b1;

    // Single read, slave acks on 3rd BUSY cycle
    set_m(1, 1, 0, 32'h100, 32'h0);
    smp(); chk("rd_idle_k", busy, 0);
    cyc(); smp();
    chk("rd_sreq", s_req, 1);
    chk("rd_saddr", s_addr, 32'h100);
    chk("rd_swe", s_we, 0);
    chk("rd_gnt", gnt_idx, 1);
    chk("rd_noack1", m_ack, 0);
    cyc(); smp(); chk("rd_noack2", m_ack, 0);
    cyc(); s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    smp();
    chk("rd_ack", m_ack, 3'b010);
    chk("rd_rdata", m_rdata, 32'hDEADBEEF);
    cyc(); s_ack = 1'b0; set_m(1, 0, 0, 32'h0, 32'h0);
    smp();
    chk("rd_done_busy", busy, 0);
    chk("rd_done_ack", m_ack, 0);

    // Pointer now past master 1: master 2 beats master 0
    set_m(0, 1, 0, 32'h200, 32'h0);
    set_m(2, 1, 0, 32'h300, 32'h0);
    cyc(); smp();
    chk("ptr_gnt2", gnt_idx, 2);
    chk("ptr_addr2", s_addr, 32'h300);
    cyc(); s_ack = 1'b1; smp(); chk("ptr_ack2", m_ack, 3'b100);
    cyc(); s_ack = 1'b0; set_m(2, 0, 0, 32'h0, 32'h0); smp();
    cyc(); smp();
    chk("ptr_gnt0", gnt_idx, 0);
    chk("ptr_addr0", s_addr, 32'h200);
    cyc(); s_ack = 1'b1; smp(); chk("ptr_ack0", m_ack, 3'b001);
    cyc(); s_ack = 1'b0; set_m(0, 0, 0, 32'h0, 32'h0); smp();

    // Round-robin, all requesting, zero-wait slave
    do_reset();
    m_req = 3'b111; s_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      smp();
      chk("rr_ack", m_ack, (c % 2 == 1) ? (64'(1) << ((c / 2) % 3)) : 64'(0));
      cyc();
    end
    m_req = '0; s_ack = 1'b0;

    // Write routing while master 1 waits
    do_reset();
    set_m(0, 1, 1, 32'h20, 32'h55AA);
    set_m(1, 1, 0, 32'h40, 32'h0);
    smp(); chk("wr_idle_ack", m_ack, 0);
    cyc(); smp();
    chk("wr_swe", s_we, 1);
    chk("wr_saddr", s_addr, 32'h20);
    chk("wr_swdata", s_wdata, 32'h55AA);
    chk("wr_gnt", gnt_idx, 0);
    chk("wr_m1_wait", m_ack, 0);
    cyc(); s_ack = 1'b1; smp(); chk("wr_ack0", m_ack, 3'b001);
    cyc(); s_ack = 1'b0; set_m(0, 0, 0, 32'h0, 32'h0); smp();
    chk("wr_gap_ack", m_ack, 0);
    cyc(); smp();
    chk("wr_gnt1", gnt_idx, 1);
    chk("wr_saddr1", s_addr, 32'h40);
    chk("wr_swe1", s_we, 0);
    cyc(); s_ack = 1'b1; s_rdata = 32'h1234; smp();
    chk("wr_ack1", m_ack, 3'b010);
    cyc(); s_ack = 1'b0; set_m(1, 0, 0, 32'h0, 32'h0); smp();

    // Reset mid-BUSY
    set_m(2, 1, 0, 32'h77, 32'h0);
    cyc(); smp();
    chk("mr_busy_before", busy, 1);
    s_ack = 1'b1; rst = 1'b0;
    #1;
    chk("mr_sreq", s_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ack", m_ack, 0);
    cyc();
    s_ack = 1'b0; rst = 1'b1;
    set_m(0, 1, 0, 32'h88, 32'h0);
    smp();
    chk("mr_gnt_rst", gnt_idx, 0);
    chk("mr_idle", busy, 0);
    cyc(); smp();
    chk("mr_ptr0", gnt_idx, 0);
    cyc(); s_ack = 1'b1; smp(); chk("mr_ack0", m_ack, 3'b001);
    cyc(); s_ack = 1'b0; m_req = '0; smp();

    // Spurious s_ack in IDLE
    s_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("sp_ack", m_ack, 0);
      chk("sp_busy", busy, 0);
      cyc();
    end
    s_ack = 1'b0;
    set_m(1, 1, 0, 32'h99, 32'h0);
    smp(); chk("sp_still_idle", busy, 0);
    cyc(); smp(); chk("sp_grant", gnt_idx, 1);
    cyc(); s_ack = 1'b1; smp(); chk("sp_ack1", m_ack, 3'b010);
    cyc(); s_ack = 1'b0; m_req = '0;

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog abort on 4th BUSY cycle, then ack on 4th cycle wins
    do_reset();
    set_m(0, 1, 0, 32'hA0, 32'h0);
    set_m(1, 1, 0, 32'hB0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); smp();
      chk("to_err", m_err, (c == 4) ? 64'b001 : 64'b0);
      chk("to_noack", m_ack, 0);
    end
    cyc(); set_m(0, 0, 0, 32'h0, 32'h0); smp(); chk("to_idle", busy, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 4) s_ack = 1'b1;
      smp();
      if (c == 1) chk("to_next_gnt", gnt_idx, 1);
      chk("to2_err", m_err, 0);
      chk("to2_ack", m_ack, (c == 4) ? 64'b010 : 64'b0);
    end
    cyc(); s_ack = 1'b0; m_req = '0;
`endif

    // Randomized traffic vs transaction-level model
    do_reset();
    mbusy = 1'b0; mgnt = 0; mptr = 0; mcnt = 0;
    exp_busy = 1'b0;
    mon_en = 1'b1;
    for (int it = 0; it < 800; it++) begin
      cyc();
      if (mbusy) begin
        if (s_ack) begin
          mbusy = 1'b0;
          mptr = (mgnt + 1) % N;
          m_req[mgnt] = 1'b0;
        end else begin
          mcnt++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int w;
          w = (mptr + k) % N;
          if (!mbusy && m_req[w]) begin
            txn_t t;
            mbusy = 1'b1; mgnt = w; mcnt = 0;
            t.idx = w; t.we = m_we[w];
            t.addr = m_addr[w*AW +: AW]; t.wdata = m_wdata[w*DW +: DW];
            q.push_back(t);
          end
        end
      end
      if (it < 780) begin
        for (int i = 0; i < N; i++) begin
          if (!m_req[i] && ($urandom % 3 == 0))
            set_m(i, 1, 1'($urandom % 2), $urandom, $urandom);
        end
      end
      if (mbusy) s_ack = (mcnt >= 2) ? 1'b1 : 1'($urandom % 3 == 0);
      else       s_ack = 1'($urandom % 5 == 0);
      s_rdata  = $urandom;
      exp_busy = mbusy;
    end
    smp();
    mon_en = 1'b0;
    chk("rnd_drained", q.size(), 0);
    checks++;
    if (done_cnt < 50) begin
      failures++;
      $display("FAIL rnd_traffic completed=%0d required_min=50", done_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
